// File: rtl/sum_accumulator.sv
// Running single-precision float accumulator with CLEAR / GO / READ commands.
// Each GO folds x_one then x_two into the sum through a 3-step ALIGN / ADD / NORM adder.
module sum_accumulator #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int N_WIDTH        = 2,
  parameter int STATE_WIDTH    = 3,
  parameter logic [N_WIDTH-1:0] CLEAR = 2'd0,
  parameter logic [N_WIDTH-1:0] GO    = 2'd1,
  parameter logic [N_WIDTH-1:0] READ  = 2'd2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic [N_WIDTH-1:0]        n,
  input  logic [FLT_DATA_WIDTH-1:0] x_one,
  input  logic [FLT_DATA_WIDTH-1:0] x_two,
  output logic [FLT_DATA_WIDTH-1:0] result,
  output logic                      done
);

  localparam logic [FLT_DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE, A_ALIGN, A_ADD, A_NORM, B_ALIGN, B_ADD, B_NORM, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [FLT_DATA_WIDTH-1:0] sum_reg, result_reg, x_one_reg, x_two_reg;
  logic                      cmd_done_reg;

  // ALIGN -> ADD pipeline registers
  logic                      al_sign_reg, al_sub_reg, al_spec_reg;
  logic [7:0]                al_exp_reg;
  logic [23:0]               al_big_reg, al_small_reg;
  logic [FLT_DATA_WIDTH-1:0] al_spec_val_reg;

  // ADD -> NORM pipeline registers
  logic                      ad_sign_reg, ad_spec_reg;
  logic [7:0]                ad_exp_reg;
  logic [24:0]               ad_mant_reg;
  logic [FLT_DATA_WIDTH-1:0] ad_spec_val_reg;

  logic accept;
  assign accept = (state_reg == IDLE) && start && clk_en;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && (n == GO)) state_next = A_ALIGN;
      A_ALIGN: state_next = A_ADD;
      A_ADD:   state_next = A_NORM;
      A_NORM:  state_next = B_ALIGN;
      B_ALIGN: state_next = B_ADD;
      B_ADD:   state_next = B_NORM;
      B_NORM:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALIGN: the running sum is operand a, the captured term is operand b.
  logic [FLT_DATA_WIDTH-1:0] op_b;
  logic        a_nan, a_inf, b_nan, b_inf, a_big;
  logic [7:0]  a_exp, b_exp, exp_diff;
  logic [23:0] a_mant, b_mant, small_mant;
  logic        al_sign_next, al_sub_next, al_spec_next;
  logic [7:0]  al_exp_next;
  logic [23:0] al_big_next, al_small_next;
  logic [FLT_DATA_WIDTH-1:0] al_spec_val_next;

  always_comb begin
    op_b   = (state_reg == B_ALIGN) ? x_two_reg : x_one_reg;
    a_exp  = sum_reg[30:23];
    b_exp  = op_b[30:23];
    a_nan  = (a_exp == 8'hFF) && (sum_reg[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (op_b[22:0] != 23'd0);
    a_inf  = (a_exp == 8'hFF) && (sum_reg[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (op_b[22:0] == 23'd0);
    // exponent 0 means zero here: denormals lose their mantissa
    a_mant = (a_exp == 8'd0) ? 24'd0 : {1'b1, sum_reg[22:0]};
    b_mant = (b_exp == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
    a_big  = {a_exp, a_mant} >= {b_exp, b_mant};

    al_sign_next  = a_big ? sum_reg[31] : op_b[31];
    al_sub_next   = sum_reg[31] ^ op_b[31];
    al_exp_next   = a_big ? a_exp : b_exp;
    al_big_next   = a_big ? a_mant : b_mant;
    small_mant    = a_big ? b_mant : a_mant;
    exp_diff      = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
    al_small_next = (exp_diff >= 8'd24) ? 24'd0 : (small_mant >> exp_diff);

    al_spec_next     = 1'b1;
    al_spec_val_next = QNAN;
    if (a_nan || b_nan)      al_spec_val_next = QNAN;
    else if (a_inf && b_inf) al_spec_val_next = (sum_reg[31] == op_b[31]) ? sum_reg : QNAN;
    else if (a_inf)          al_spec_val_next = sum_reg;
    else if (b_inf)          al_spec_val_next = op_b;
    else                     al_spec_next = 1'b0;
  end

  // The base always has the larger magnitude, so the subtraction never goes negative.
  logic [24:0] ad_mant_next;
  assign ad_mant_next = al_sub_reg ? ({1'b0, al_big_reg} - {1'b0, al_small_reg})
                                   : ({1'b0, al_big_reg} + {1'b0, al_small_reg});

  // NORM: renormalise, truncate, then apply overflow / underflow limits.
  logic [4:0]  lz;
  logic        lz_found;
  logic signed [9:0] norm_exp;
  logic [23:0] norm_shift;
  logic [22:0] norm_frac;
  logic [FLT_DATA_WIDTH-1:0] norm_val;

  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!lz_found) begin
        if (ad_mant_reg[i]) lz_found = 1'b1;
        else                lz = lz + 5'd1;
      end
    end
    norm_shift = ad_mant_reg[23:0] << lz;
    norm_exp   = $signed({2'b00, ad_exp_reg});
    norm_frac  = norm_shift[22:0];
    if (ad_mant_reg[24]) begin
      norm_exp  = norm_exp + 10'sd1;
      norm_frac = ad_mant_reg[23:1];
    end else begin
      norm_exp  = norm_exp - $signed({5'd0, lz});
    end

    if (ad_spec_reg)                  norm_val = ad_spec_val_reg;
    else if (ad_mant_reg == 25'd0)    norm_val = '0;
    else if (norm_exp >= 10'sd255)    norm_val = {ad_sign_reg, 8'hFF, 23'd0};
    else if (norm_exp <= 10'sd0)      norm_val = '0;
    else                              norm_val = {ad_sign_reg, norm_exp[7:0], norm_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      sum_reg         <= '0;
      result_reg      <= '0;
      cmd_done_reg    <= 1'b0;
      x_one_reg       <= '0;
      x_two_reg       <= '0;
      al_sign_reg     <= 1'b0;
      al_sub_reg      <= 1'b0;
      al_spec_reg     <= 1'b0;
      al_exp_reg      <= '0;
      al_big_reg      <= '0;
      al_small_reg    <= '0;
      al_spec_val_reg <= '0;
      ad_sign_reg     <= 1'b0;
      ad_spec_reg     <= 1'b0;
      ad_exp_reg      <= '0;
      ad_mant_reg     <= '0;
      ad_spec_val_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            x_one_reg <= x_one;
            x_two_reg <= x_two;
            if (n == CLEAR) begin
              sum_reg      <= '0;
              result_reg   <= '0;
              cmd_done_reg <= 1'b1;
            end else if (n != GO) begin
              // READ and the reserved code both report the sum untouched
              result_reg   <= sum_reg;
              cmd_done_reg <= 1'b1;
            end
          end
        end
        A_ALIGN, B_ALIGN: begin
          al_sign_reg     <= al_sign_next;
          al_sub_reg      <= al_sub_next;
          al_spec_reg     <= al_spec_next;
          al_exp_reg      <= al_exp_next;
          al_big_reg      <= al_big_next;
          al_small_reg    <= al_small_next;
          al_spec_val_reg <= al_spec_val_next;
        end
        A_ADD, B_ADD: begin
          ad_sign_reg     <= al_sign_reg;
          ad_spec_reg     <= al_spec_reg;
          ad_exp_reg      <= al_exp_reg;
          ad_mant_reg     <= ad_mant_next;
          ad_spec_val_reg <= al_spec_val_reg;
        end
        A_NORM: sum_reg <= norm_val;
        B_NORM: begin
          // result is loaded alongside the sum so it is valid while DONE drives done
          sum_reg    <= norm_val;
          result_reg <= norm_val;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign done   = (state_reg == DONE) || cmd_done_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: command latency, float sums and special cases.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  n = 2'd0;
  logic [31:0] x_one = '0;
  logic [31:0] x_two = '0;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] C_CLEAR = 2'd0, C_GO = 2'd1, C_READ = 2'd2, C_RSVD = 2'd3;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
    .x_one(x_one), .x_two(x_two), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Issue one command; return latency from the acceptance edge (0 = never done).
  task automatic issue(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; n = cmd; x_one = a; x_two = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    issue(cmd, a, b, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    $display("%s: cmd=%0d x_one=0x%08h x_two=0x%08h lat=%0d result=0x%08h",
             tag, cmd, a, b, lat, result);
  endtask

  initial begin
    int lat;
    int dones;

    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    // 1: 1.0 + 2.0
    run_cmd("t1_clear", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("t1_go", C_GO, 32'h3F800000, 32'h40000000, 7, 32'h40400000);

    // 2: +0.5 then -3.5 cancels exactly
    run_cmd("t2_go", C_GO, 32'h3F000000, 32'hC0600000, 7, 32'h00000000);
    run_cmd("t2_read", C_READ, 32'h0, 32'h0, 1, 32'h00000000);

    // 3: overflow to +inf
    run_cmd("t3_clear", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("t3_go", C_GO, 32'h7F7FFFFF, 32'h7F7FFFFF, 7, 32'h7F800000);
    run_cmd("t3_read", C_READ, 32'h0, 32'h0, 1, 32'h7F800000);
    run_cmd("t3_clear2", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);

    // 4: denormal flushed; start pulses during the GO are ignored
    @(negedge clk);
    start = 1'b1; n = C_GO; x_one = 32'h40400000; x_two = 32'h00000001;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k >= 2 && k <= 6);
      n = C_GO; x_one = 32'h3F800000; x_two = 32'h3F800000;
      if (done) begin
        dones++;
        check("t4_lat", k, 7);
        check("t4_res", result, 32'h40400000);
      end
    end
    start = 1'b0;
    check("t4_dones", dones, 1);
    $display("t4: GO 0x40400000 + 0x00000001 with extra starts, dones=%0d", dones);
    run_cmd("t4_read", C_READ, 32'h0, 32'h0, 1, 32'h40400000);

    // 5: reset during B_ADD aborts the GO
    @(negedge clk);
    start = 1'b1; n = C_GO; x_one = 32'h3F800000; x_two = 32'h40000000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_result", result, 32'h0);
    rst = 1'b0;
    $display("t5: reset in B_ADD, done=%0d result=0x%08h", done, result);
    run_cmd("t5_read", C_READ, 32'h0, 32'h0, 1, 32'h00000000);
    clk_en = 1'b0;
    dones = 0;
    @(negedge clk);
    start = 1'b1; n = C_READ;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    clk_en = 1'b1;
    check("t5_clk_en_low", dones, 0);
    $display("t5: start with clk_en=0, dones=%0d", dones);

    // extra: subtraction with renormalisation and a negative result
    run_cmd("x_clear", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("x_sub", C_GO, 32'h40400000, 32'hBF800000, 7, 32'h40000000);
    run_cmd("x_neg", C_GO, 32'h3F800000, 32'hC0800000, 7, 32'hBF800000);
    // extra: inf + -inf and NaN inputs give the quiet NaN
    run_cmd("x_clear2", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("x_infinf", C_GO, 32'h7F800000, 32'hFF800000, 7, 32'h7FC00000);
    run_cmd("x_clear3", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("x_nan", C_GO, 32'h3F800000, 32'h7F800001, 7, 32'h7FC00000);
    run_cmd("x_clear4", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("x_ninf", C_GO, 32'hFF800000, 32'h3F800000, 7, 32'hFF800000);

    // 6: truncation of 1.0 + 2^-24, then reserved command
    run_cmd("t6_clear", C_CLEAR, 32'h0, 32'h0, 1, 32'h0);
    run_cmd("t6_go", C_GO, 32'h3F800000, 32'h33800000, 7, 32'h3F800000);
    run_cmd("t6_rsvd", C_RSVD, 32'h0, 32'h0, 1, 32'h3F800000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
